// File: rtl/dvp_pattern_tx.sv
// DVP (OV7670-style) RGB565 test-pattern source; pclk = clk_25/2, one tick = two clk_25 cycles.
// Define DVP_TX_LFSR_EN to replace the checkerboard (pattern 3) with a per-frame 16-bit LFSR.
module dvp_pattern_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       pclk,
  output logic       vsync,
  output logic       h_ref,
  output logic [7:0] data_out,
  output logic       frame_done
);

  localparam int LINE_BYTES = (H_ACTIVE + H_BLANK) * 2;
  localparam int ACT_BYTES  = H_ACTIVE * 2;
  localparam int BW         = $clog2(LINE_BYTES);
  localparam int V_MAX_A    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int V_MAX_B    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX      = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int LW         = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [BW-1:0] LAST_BYTE = BW'(LINE_BYTES - 1);
  localparam logic [BW-1:0] ACT_END   = BW'(ACT_BYTES);
  localparam logic [LW-1:0] VS_LAST   = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VB_LAST   = LW'(V_BACK - 1);
  localparam logic [LW-1:0] VA_LAST   = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] VF_LAST   = LW'(V_FRONT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t        state, state_d;
  logic          phase, phase_d;      // 0: next edge loads a new tick, 1: next edge raises pclk
  logic [BW-1:0] byte_cnt, byte_d;
  logic [LW-1:0] line_cnt, line_d;
  logic [1:0]    pat;
  logic          start_frame, frame_end, line_last, byte_last, active_byte;
  logic [15:0]   pixel;
  logic [2:0]    bar_idx;
  logic [5:0]    ramp_g;
  logic [7:0]    pix_byte;

  assign byte_last   = (byte_cnt == LAST_BYTE);
  assign active_byte = (state == S_ACTIVE) && (byte_cnt < ACT_END);

  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d     = state;
    phase_d     = phase;
    byte_d      = byte_cnt;
    line_d      = line_cnt;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    line_last   = 1'b0;

    unique case (state)
      S_VSYNC:  line_last = (line_cnt == VS_LAST);
      S_VBACK:  line_last = (line_cnt == VB_LAST);
      S_ACTIVE: line_last = (line_cnt == VA_LAST);
      S_VFRONT: line_last = (line_cnt == VF_LAST);
      default:  line_last = 1'b0;
    endcase

    if (state == S_IDLE) begin
      phase_d = 1'b0;
      if (enable) begin
        state_d     = S_VSYNC;
        start_frame = 1'b1;
        byte_d      = '0;
        line_d      = '0;
      end
    end else if (!phase) begin
      phase_d = 1'b1;
    end else begin
      // Position advances on the pclk-rise edge, so the next load edge sees the new tick.
      phase_d = 1'b0;
      if (byte_last) begin
        byte_d = '0;
        if (line_last) begin
          line_d = '0;
          unique case (state)
            S_VSYNC:  state_d = S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFRONT;
            default: begin
              frame_end = 1'b1;
              if (enable) begin
                state_d     = S_VSYNC;
                start_frame = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end
          endcase
        end else begin
          line_d = line_cnt + 1'b1;
        end
      end else begin
        byte_d = byte_cnt + 1'b1;
      end
    end
  end

`ifdef DVP_TX_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Taps 16,14,13,11 in right-shift form; the pixel shows the state before the step.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk_25) begin
    if (reset || start_frame) lfsr <= LFSR_SEED;
    else if (!phase && active_byte && byte_cnt[0]) lfsr <= {lfsr_fb, lfsr[15:1]};
  end
`endif

  always_comb begin
    bar_idx = 3'((32'(byte_cnt >> 1) * 32'd8) / 32'(H_ACTIVE));
    ramp_g  = 6'(32'(byte_cnt >> 1) >> 4);
    pixel   = 16'hFFFF;
    case (pat)
      2'd0: pixel = 16'hFFFF;
      2'd1: begin
        case (bar_idx)
          3'd0: pixel = 16'hFFFF;
          3'd1: pixel = 16'hFFE0;
          3'd2: pixel = 16'h07FF;
          3'd3: pixel = 16'h07E0;
          3'd4: pixel = 16'hF81F;
          3'd5: pixel = 16'hF800;
          3'd6: pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd2: pixel = {ramp_g[5:1], ramp_g, ramp_g[5:1]};
      default: begin
`ifdef DVP_TX_LFSR_EN
        pixel = lfsr;
`else
        pixel = (1'(32'(byte_cnt >> 1) >> 5) ^ 1'(32'(line_cnt) >> 5)) ? 16'hFFFF : 16'h0000;
`endif
      end
    endcase
    pix_byte = byte_cnt[0] ? pixel[7:0] : pixel[15:8];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= 1'b0;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      pat        <= '0;
      pclk       <= 1'b0;
      vsync      <= 1'b0;
      h_ref      <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      byte_cnt   <= byte_d;
      line_cnt   <= line_d;
      frame_done <= frame_end;
      if (start_frame) pat <= pattern_sel;

      if (state == S_IDLE) begin
        pclk     <= 1'b0;
        vsync    <= 1'b0;
        h_ref    <= 1'b0;
        data_out <= '0;
      end else if (!phase) begin
        pclk     <= 1'b0;
        vsync    <= (state == S_VSYNC);
        h_ref    <= active_byte;
        data_out <= active_byte ? pix_byte : 8'h00;
      end else begin
        pclk <= 1'b1;
      end
    end
  end

endmodule
